// File: rtl/clkgate_basic_regfile_pkg.sv
// clkgate_basic_regfile_pkg: shared sizing defaults, word type and reset value for the gated register file
package clkgate_basic_regfile_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 2 ** DEF_ADDR_W;
  typedef logic [DEF_DATA_W-1:0] word_t;
  localparam word_t RST_VAL = '0;
endpackage

// File: rtl/clkgate_basic_regfile_cell.sv
// clkgate_basic_regfile_cell: glitch-free ICG (clk, rstn, en -> gclk), low-transparent latch plus AND
module clkgate_basic_regfile_cell (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic gclk
);
  logic en_lat;
  always_latch
    if (!rstn) en_lat <= 1'b0;
    else if (!clk) en_lat <= en;
  assign gclk = clk & en_lat;
endmodule

// File: rtl/clkgate_basic_regfile.sv
// clkgate_basic_regfile: clock-gated regfile (clk, rstn, clken, wr_en, addr, data -> registered q)
module clkgate_basic_regfile
  import clkgate_basic_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clken,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);
  logic gclk;
  logic [DATA_W-1:0] mem [DEPTH];
  clkgate_basic_regfile_cell u_cell (
    .clk  (clk),
    .rstn (rstn),
    .en   (clken),
    .gclk (gclk)
  );
  always_ff @(posedge gclk or negedge rstn)
    if (!rstn) mem <= '{default: DATA_W'(RST_VAL)};
    else if (wr_en) mem[addr] <= data;
  always_ff @(posedge gclk or negedge rstn)
    if (!rstn) q <= DATA_W'(RST_VAL);
    else if (!wr_en) q <= mem[addr];
endmodule

// File: tb/tb_clkgate_basic_regfile.sv
// tb_clkgate_basic_regfile: randomized and directed checks of the gated regfile against an array model
module tb_clkgate_basic_regfile;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clken = 1'b1;
  logic wr_en = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data = '0;
  logic [7:0] q;
  int checks = 0;
  int errors = 0;
  int gcnt = 0;
  logic [7:0] ref_mem [16];
  logic [7:0] ref_q;
  clkgate_basic_regfile dut (
    .clk   (clk),
    .rstn  (rstn),
    .clken (clken),
    .wr_en (wr_en),
    .addr  (addr),
    .data  (data),
    .q     (q)
  );
  always #5 clk = ~clk;
  always @(posedge dut.gclk) gcnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic ce, input logic we, input logic [3:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    clken = ce;
    wr_en = we;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
    if (ce) begin
      if (we) ref_mem[a] = d;
      else ref_q = ref_mem[a];
    end
    chk(tag, {24'd0, q}, {24'd0, ref_q});
  endtask
  initial begin
    int g0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_q = 8'h00;
    #7;
    chk("reset_q", {24'd0, q}, 32'h0);
    chk("reset_no_gclk", gcnt, 0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 4'(3 + i), 8'(8'h31 + i), "burst_write_q");
    g0 = gcnt;
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'($urandom), 4'($urandom), 8'($urandom), "gated_idle_q");
    chk("gated_idle_no_gclk", gcnt, g0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 4'(3 + i), 8'($urandom), "burst_read_q");
    chk("burst_read_last", {24'd0, q}, 32'h3A);
    @(negedge clk);
    clken = 1'b0;
    g0 = gcnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 clken = 1'b1;
      #2 clken = 1'b0;
      @(negedge clk);
      #1 clken = 1'b1;
      #2 clken = 1'b0;
    end
    #1;
    chk("glitch_no_gclk", gcnt, g0);
    chk("glitch_q_hold", {24'd0, q}, 32'h3A);
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 8'($urandom), "random_q");
    cyc(1'b1, 1'b1, 4'h5, 8'hA5, "pre_reset_write_q");
    cyc(1'b1, 1'b0, 4'h5, 8'h00, "pre_reset_read_q");
    chk("pre_reset_q_nonzero", {24'd0, q}, 32'hA5);
    cyc(1'b1, 1'b0, 4'h6, 8'h00, "read_burst_q");
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midop_reset_q", {24'd0, q}, 32'h0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_q = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 1'b0, 4'h5, 8'h00, "post_reset_read5");
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i), 8'h00, "post_reset_mem_zero");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
